// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard
// Decode-stage integer register file with a busy scoreboard, write-back bypass and a
// registered valid/ready operand stage feeding execute.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid / in_ready        decoded instruction handshake (in_ready is combinational)
//   rs1_addr, rs2_addr         source register indices
//   rd_addr, rd_we             destination index and write intent
//   pc, imm                    instruction PC and decoded immediate
//   op1_sel, op2_sel           operand source selects
//   wb_en, wb_addr, wb_data    write-back port
//   out_valid / out_ready      operand bundle handshake towards execute
//   op1_data, op2_data         registered selected operands
//   out_rd_addr, out_rd_we     registered destination (rd_we gated off for x0)
//   busy_count                 number of registers marked busy
module reg_file_scoreboard #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     NREG     = 32,
   parameter int unsigned     AW       = $clog2(NREG),
   parameter int unsigned     SP_INDEX = 2,
   parameter logic [XLEN-1:0] SP_RESET = XLEN'(32'h100)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   input  logic [AW-1:0]   rd_addr,
   input  logic            rd_we,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm,
   input  logic [1:0]      op1_sel,
   input  logic [2:0]      op2_sel,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] op1_data,
   output logic [XLEN-1:0] op2_data,
   output logic [AW-1:0]   out_rd_addr,
   output logic            out_rd_we,
   output logic [AW:0]     busy_count
);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic [NREG-1:0] busy_q, busy_d;
   logic [AW:0]     busy_count_q, busy_count_d;
   logic            out_valid_q, out_valid_d;
   logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d;
   logic [AW-1:0]   out_rd_addr_q, out_rd_addr_d;
   logic            out_rd_we_q, out_rd_we_d;

   logic            wb_live;
   logic            src1_used, src2_used, rd_live;
   logic            wb_hit1, wb_hit2, wb_hit_rd;
   logic [XLEN-1:0] rs1_val, rs2_val;
   logic            hazard, accept;

   // Write-back to x0 is a no-op, so it never bypasses or clears anything.
   assign wb_live   = wb_en && (wb_addr != '0);
   assign src1_used = (op1_sel == 2'd1) && (rs1_addr != '0);
   assign src2_used = (op2_sel == 3'd1) && (rs2_addr != '0);
   assign rd_live   = rd_we && (rd_addr != '0);
   assign wb_hit1   = wb_live && (wb_addr == rs1_addr);
   assign wb_hit2   = wb_live && (wb_addr == rs2_addr);
   assign wb_hit_rd = wb_live && (wb_addr == rd_addr);

   assign rs1_val = wb_hit1 ? wb_data : regs_q[rs1_addr];
   assign rs2_val = wb_hit2 ? wb_data : regs_q[rs2_addr];

   // A register being written back this cycle is effectively no longer busy.
   assign hazard = (src1_used && busy_q[rs1_addr] && !wb_hit1) ||
                   (src2_used && busy_q[rs2_addr] && !wb_hit2) ||
                   (rd_live   && busy_q[rd_addr]  && !wb_hit_rd);

   assign in_ready = !hazard && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      regs_d = regs_q;
      if (wb_live) regs_d[wb_addr] = wb_data;
   end

   // Clear first, then set, so a same-cycle issue to the written register stays pending.
   always_comb begin
      busy_d = busy_q;
      if (wb_live) busy_d[wb_addr] = 1'b0;
      if (accept && rd_live) busy_d[rd_addr] = 1'b1;
      busy_count_d = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         busy_count_d = busy_count_d + (AW+1)'(busy_d[i]);
      end
   end

   always_comb begin
      out_valid_d   = out_valid_q;
      op1_d         = op1_q;
      op2_d         = op2_q;
      out_rd_addr_d = out_rd_addr_q;
      out_rd_we_d   = out_rd_we_q;
      if (accept) begin
         out_valid_d   = 1'b1;
         out_rd_addr_d = rd_addr;
         out_rd_we_d   = rd_live;
         case (op1_sel)
            2'd1:    op1_d = rs1_val;
            2'd2:    op1_d = pc;
            default: op1_d = '0;
         endcase
         case (op2_sel)
            3'd1:                   op2_d = rs2_val;
            3'd2, 3'd3, 3'd4, 3'd5: op2_d = imm;
            default:                op2_d = '0;
         endcase
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs_q[i] <= (i == SP_INDEX) ? SP_RESET : '0;
         end
         busy_q        <= '0;
         busy_count_q  <= '0;
         out_valid_q   <= 1'b0;
         op1_q         <= '0;
         op2_q         <= '0;
         out_rd_addr_q <= '0;
         out_rd_we_q   <= 1'b0;
      end else begin
         regs_q        <= regs_d;
         busy_q        <= busy_d;
         busy_count_q  <= busy_count_d;
         out_valid_q   <= out_valid_d;
         op1_q         <= op1_d;
         op2_q         <= op2_d;
         out_rd_addr_q <= out_rd_addr_d;
         out_rd_we_q   <= out_rd_we_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign op1_data    = op1_q;
   assign op2_data    = op2_q;
   assign out_rd_addr = out_rd_addr_q;
   assign out_rd_we   = out_rd_we_q;
   assign busy_count  = busy_count_q;

endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
Parametrised successor to the decode-stage register file for the RISC-V core. Holds the architectural integer registers and selects operands (register, PC, immediate or zero) for the execute stage. Adds three things the earlier block lacked: a per-register busy scoreboard with hazard stall, write-back-to-read bypass, and a registered valid/ready output stage. It sits between decode and execute, and write-back feeds it directly.

Parameters:
XLEN, 32, data/PC/immediate width
NREG, 32, number of architectural registers (power of 2); register 0 hardwired to zero
AW, $clog2(NREG), register address width (derived)
SP_INDEX, 2, register preset at reset as stack pointer
SP_RESET, 32'h100, reset value of register SP_INDEX

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_valid  in  1  decoded instruction present
in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
rs1_addr  in  AW  source 1 index
rs2_addr  in  AW  source 2 index
rd_addr  in  AW  destination index
rd_we  in  1  instruction will write rd
pc  in  XLEN  instruction PC
imm  in  XLEN  decoded immediate
op1_sel  in  2  0=zero, 1=RS1, 2=PC, 3=reserved (drives 0)
op2_sel  in  3  0=zero, 1=RS2, 2..5=IMM (I/S/J/U forms), 6..7=reserved (drives 0)
wb_en  in  1  write-back strobe
wb_addr  in  AW  write-back index
wb_data  in  XLEN  write-back value
out_valid  out  1  operand bundle valid
out_ready  in  1  execute stage accepts the bundle
op1_data  out  XLEN  selected operand 1
op2_data  out  XLEN  selected operand 2
out_rd_addr  out  AW  registered rd_addr
out_rd_we  out  1  registered rd_we (forced 0 when rd_addr==0)
busy_count  out  AW+1  number of registers currently marked busy

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high.
- Reset:
  - All registers are cleared to 0, except register SP_INDEX, which is set to SP_RESET.
  - All busy bits are cleared.
  - out_valid=0; op1_data, op2_data, out_rd_addr, out_rd_we = 0; busy_count=0.
  - Reset mid-operation discards any held bundle and all pending scoreboard state.
- Register write:
  - wb_en with wb_addr!=0 writes wb_data at the clock edge.
  - wb_addr==0 is ignored; register 0 always reads 0.
  - A write-back to a non-busy register is legal: it writes and leaves the scoreboard unchanged.
- Source usage: src1 is used iff op1_sel==1 && rs1_addr!=0; src2 is used iff op2_sel==1 && rs2_addr!=0.
- Bypass: if a used source matches wb_addr while wb_en is high, the operand takes wb_data in the same cycle, not the stale register value.
- Hazard (stall) is asserted if either holds:
  - RAW: a used source is busy and is not being written back this cycle.
  - WAW: rd_we && rd_addr!=0, rd is busy, and rd is not being written back this cycle.
- Ready rule: in_ready = !hazard && (!out_valid || out_ready). in_ready is combinational; it must not depend on in_valid.
- Scoreboard update at the clock edge:
  - Accepting an instruction with rd_we && rd_addr!=0 sets busy[rd_addr].
  - wb_en clears busy[wb_addr].
  - If both target the same register in one cycle, set wins (a new pending write).
  - busy_count is a registered popcount of the busy bits, updated in the same cycle as them.
- Output stage: one-cycle latency from acceptance to out_valid.
  - On acceptance, the selected operands, rd_addr and the gated rd_we are registered, and out_valid=1.
  - If out_valid && !out_ready, all outputs hold stable.
  - If out_valid && out_ready && no new acceptance, out_valid goes to 0 next cycle.
  - Back-to-back acceptance sustains 1 instruction per cycle.
- Operand selection:
  - op1: zero → 0; RS1 → register/bypass value; PC → pc.
  - op2: zero → 0; RS2 → register/bypass value; IMM → imm.
  - Reserved encodings drive 0, never X.
- No arithmetic or width conversion is performed; all values are XLEN-wide and passed through unchanged.

Test Plan:
- Reset check: assert reset 1 cycle, then issue op1_sel=1/rs1=2 and op2_sel=1/rs2=5 -> op1_data=0x100, op2_data=0, out_valid=1 one cycle after acceptance, busy_count=0.
- x0 protection: wb_en, wb_addr=0, wb_data=0xDEADBEEF; then read rs1=0 -> op1_data=0, no stall.
- RAW stall and bypass: issue rd=7 with rd_we; next instruction reads rs1=7 -> in_ready=0 and busy_count=1. Then pulse wb_en with wb_addr=7, wb_data=0x1234 -> accepted that cycle, op1_data=0x1234, busy_count=0.
- Same-cycle set/clear: with x9 busy, issue rd=9 while wb_addr=9 write-back occurs -> instruction accepted, busy[9] remains set, busy_count=1.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> outputs stable and in_ready=0. Release -> next bundle appears on the following cycle with no loss or duplication.
- Operand modes: op1_sel=2 with pc=0x80; op2_sel=4 with imm=0xFFFFF800 -> op1_data=0x80, op2_data=0xFFFFF800. Reserved op2_sel=7 -> op2_data=0.
